// File: rtl/ethernet_rx_packet_ring_if.sv
// ethernet_rx_packet_ring_if
//   Bundles the MAC-side RX byte stream and the software MMIO window of the
//   RX packet ring.
//   master : drives the stream beats and MMIO strobes (MAC + software side)
//   slave  : the ring itself; returns rx_ready_o, read_data_o and the
//            interrupt-pending flag
interface ethernet_rx_packet_ring_if #(
    parameter int data_width_p     = 32,
    parameter int reg_addr_width_p = 16
);
    logic                        rx_valid_i;
    logic [data_width_p-1:0]     rx_data_i;
    logic [data_width_p/8-1:0]   rx_keep_i;
    logic                        rx_last_i;
    logic                        rx_error_i;
    logic                        rx_ready_o;
    logic [reg_addr_width_p-1:0] addr_i;
    logic                        write_en_i;
    logic                        read_en_i;
    logic [1:0]                  op_size_i;
    logic [data_width_p-1:0]     write_data_i;
    logic [data_width_p-1:0]     read_data_o;
    logic                        rx_interrupt_pending_o;

    modport master (
        output rx_valid_i, rx_data_i, rx_keep_i, rx_last_i, rx_error_i,
        output addr_i, write_en_i, read_en_i, op_size_i, write_data_i,
        input  rx_ready_o, read_data_o, rx_interrupt_pending_o
    );

    modport slave (
        input  rx_valid_i, rx_data_i, rx_keep_i, rx_last_i, rx_error_i,
        input  addr_i, write_en_i, read_en_i, op_size_i, write_data_i,
        output rx_ready_o, read_data_o, rx_interrupt_pending_o
    );
endinterface

// File: rtl/ethernet_rx_packet_ring.sv
// ethernet_rx_packet_ring
//   Multi-slot RX packet buffer. Complete packets from the MAC byte stream are
//   stored in a ring of slot_count_p slots; software reads the head packet
//   through an MMIO window and pops it. Packets that do not fit (ring full,
//   oversize, bad FCS/PHY) are dropped and counted; the MAC is never stalled.
//   clk_i, reset_i : single clock, synchronous active-high reset
//   bus (slave)    : stream in (valid/data/keep/last/error, ready out),
//                    MMIO (addr/write_en/read_en/op_size/write_data in,
//                    registered read_data out), rx_interrupt_pending_o
module ethernet_rx_packet_ring #(
    parameter int buf_size_p       = 2048,
    parameter int slot_count_p     = 4,
    parameter int data_width_p     = 32,
    parameter int reg_addr_width_p = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    ethernet_rx_packet_ring_if.slave  bus
);
    localparam int BYTES  = data_width_p / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int BEATS  = buf_size_p / BYTES;
    localparam int BEAT_W = $clog2(BEATS) + 1;
    localparam int SLOT_W = $clog2(slot_count_p);
    localparam int CNT_W  = SLOT_W + 1;
    localparam int BUF_AW = $clog2(buf_size_p);
    localparam int SIZE_W = BUF_AW + 1;
    localparam int KCNT_W = OFF_W + 1;
    localparam int MEM_AW = SLOT_W + BEAT_W - 1;
    localparam int AW     = reg_addr_width_p;
    localparam int DW     = data_width_p;

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_e;

    state_e             state_q, state_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [SLOT_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DW-1:0]      drop_count_q, drop_count_d;
    logic               int_enable_q, int_enable_d;
    logic               irq_q, irq_d;
    logic [DW-1:0]      read_data_q, read_data_d;

    logic [DW-1:0]      mem_q [slot_count_p*BEATS];
    logic [SIZE_W-1:0]  size_q [slot_count_p];

    logic               mem_we, commit, drop_inc, pop;
    logic [MEM_AW-1:0]  mem_waddr;
    logic [SIZE_W-1:0]  commit_size;
    logic [KCNT_W-1:0]  keep_cnt;

    assign bus.rx_ready_o             = ~reset_i;
    assign bus.read_data_o            = read_data_q;
    assign bus.rx_interrupt_pending_o = irq_q;

    // ---------------- stream side ----------------
    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < BYTES; i++) keep_cnt += KCNT_W'(bus.rx_keep_i[i]);
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        mem_we      = 1'b0;
        mem_waddr   = {wr_ptr_q, beat_cnt_q[BEAT_W-2:0]};
        commit      = 1'b0;
        drop_inc    = 1'b0;
        commit_size = '0;
        case (state_q)
            IDLE: if (bus.rx_valid_i) begin
                // Fullness is judged only here, at packet start.
                if (count_q == CNT_W'(slot_count_p)) begin
                    if (bus.rx_last_i) drop_inc = 1'b1;
                    else               state_d  = DROP;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = {wr_ptr_q, {(BEAT_W-1){1'b0}}};
                    if (bus.rx_last_i) begin
                        drop_inc    = bus.rx_error_i;
                        commit      = ~bus.rx_error_i;
                        commit_size = SIZE_W'(keep_cnt);
                    end else begin
                        beat_cnt_d = BEAT_W'(1);
                        state_d    = RECV;
                    end
                end
            end
            RECV: if (bus.rx_valid_i) begin
                if (beat_cnt_q == BEAT_W'(BEATS)) begin
                    // Slot is already full: the packet is oversize.
                    if (bus.rx_last_i) begin
                        drop_inc = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d  = DROP;
                    end
                end else begin
                    mem_we     = 1'b1;
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (bus.rx_last_i) begin
                        state_d     = IDLE;
                        drop_inc    = bus.rx_error_i;
                        commit      = ~bus.rx_error_i;
                        commit_size = SIZE_W'({beat_cnt_q, {OFF_W{1'b0}}})
                                    + SIZE_W'(keep_cnt);
                    end
                end
            end
            DROP: if (bus.rx_valid_i && bus.rx_last_i) begin
                drop_inc = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- MMIO side ----------------
    logic [3:0]     size_bytes;
    logic           acc_ok, in_buf;
    logic [DW-1:0]  buf_word, rdata_raw, size_mask;

    always_comb begin
        size_bytes = 4'd1 << bus.op_size_i;
        acc_ok     = ((bus.op_size_i != 2'd3) || (DW == 64)) &&
                     ((bus.addr_i & AW'(size_bytes - 4'd1)) == '0);
        in_buf     = bus.addr_i < AW'(buf_size_p);
        buf_word   = mem_q[{rd_ptr_q, bus.addr_i[BUF_AW-1:OFF_W]}];
        case (bus.op_size_i)
            2'd0:    size_mask = DW'(8'hFF);
            2'd1:    size_mask = DW'(16'hFFFF);
            2'd2:    size_mask = DW'(32'hFFFF_FFFF);
            default: size_mask = '1;
        endcase
        rdata_raw = '0;
        if (in_buf) begin
            if (count_q != '0) rdata_raw = buf_word >> {bus.addr_i[OFF_W-1:0], 3'b000};
        end else begin
            case (bus.addr_i)
                AW'(16'h1004): rdata_raw = (count_q != '0) ? DW'(size_q[rd_ptr_q]) : '0;
                AW'(16'h1010): rdata_raw = DW'(count_q != '0);
                AW'(16'h1014): rdata_raw = DW'(int_enable_q);
                AW'(16'h1040): rdata_raw = DW'(count_q);
                AW'(16'h1044): rdata_raw = drop_count_q;
                default:       rdata_raw = '0;
            endcase
        end
        read_data_d = read_data_q;
        if (bus.read_en_i) read_data_d = acc_ok ? (rdata_raw & size_mask) : '0;
    end

    logic wr_ok;
    logic unused_ok;
    assign wr_ok     = bus.write_en_i && acc_ok;
    assign unused_ok = ^bus.write_data_i[DW-1:1];

    always_comb begin
        pop          = wr_ok && (bus.addr_i == AW'(16'h1010)) &&
                       bus.write_data_i[0] && (count_q != '0);
        int_enable_d = int_enable_q;
        if (wr_ok && bus.addr_i == AW'(16'h1014)) int_enable_d = bus.write_data_i[0];
        drop_count_d = drop_count_q;
        if (wr_ok && bus.addr_i == AW'(16'h1044)) drop_count_d = '0;
        else if (drop_inc && drop_count_q != '1)  drop_count_d = drop_count_q + DW'(1);
        wr_ptr_d = wr_ptr_q + SLOT_W'(commit);
        rd_ptr_d = rd_ptr_q + SLOT_W'(pop);
        count_d  = count_q + CNT_W'(commit) - CNT_W'(pop);
        irq_d    = int_enable_q && (count_q != '0);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            drop_count_q <= '0;
            int_enable_q <= 1'b0;
            irq_q        <= 1'b0;
            read_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drop_count_q <= drop_count_d;
            int_enable_q <= int_enable_d;
            irq_q        <= irq_d;
            read_data_q  <= read_data_d;
        end
    end

    // Payload and size storage carry no reset; validity comes from count_q.
    always_ff @(posedge clk_i) begin
        if (!reset_i && mem_we) mem_q[mem_waddr] <= bus.rx_data_i;
        if (!reset_i && commit) size_q[wr_ptr_q] <= commit_size;
    end
endmodule

// File: tb/tb_ethernet_rx_packet_ring.sv
module tb_ethernet_rx_packet_ring;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    ethernet_rx_packet_ring_if #(.data_width_p(DW), .reg_addr_width_p(16)) bus();

    ethernet_rx_packet_ring #(
        .buf_size_p(2048), .slot_count_p(4), .data_width_p(DW), .reg_addr_width_p(16)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] pkt_buf [0:2111];
    int         exp_len_q [$];
    logic [7:0] exp_byte_q [$];

    task automatic gen_pkt(input int len, input int seed);
        for (int i = 0; i < len; i++) pkt_buf[i] = 8'((seed * 37 + i * 5 + (i >> 8)) & 255);
    endtask

    task automatic expect_pkt(input int s, input int e);
        exp_len_q.push_back(e - s);
        for (int i = s; i < e; i++) exp_byte_q.push_back(pkt_buf[i]);
    endtask

    // Send pkt_buf[s..e) as one packet; optionally issue a pop on the last beat.
    task automatic send_range(input int s, input int e, input bit err, input bit pop_last);
        int i, n;
        i = s;
        while (i < e) begin
            n = (e - i < 4) ? e - i : 4;
            @(negedge clk);
            bus.rx_valid_i = 1'b1;
            for (int j = 0; j < 4; j++) bus.rx_data_i[8*j +: 8] = (j < n) ? pkt_buf[i + j] : 8'h00;
            bus.rx_keep_i  = 4'((1 << n) - 1);
            bus.rx_last_i  = (i + n >= e);
            bus.rx_error_i = err && (i + n >= e);
            if (pop_last && (i + n >= e)) begin
                bus.addr_i = 16'h1010; bus.op_size_i = 2'd2;
                bus.write_data_i = 32'h1; bus.write_en_i = 1'b1;
            end
            i += n;
        end
        @(negedge clk);
        bus.rx_valid_i = 1'b0; bus.rx_last_i = 1'b0; bus.rx_error_i = 1'b0;
        bus.write_en_i = 1'b0;
    endtask

    task automatic mmio_rd(input logic [15:0] a, input logic [1:0] sz, output logic [31:0] d);
        @(negedge clk);
        bus.addr_i = a; bus.op_size_i = sz; bus.read_en_i = 1'b1;
        @(negedge clk);
        bus.read_en_i = 1'b0;
        d = bus.read_data_o;
    endtask

    task automatic mmio_wr(input logic [15:0] a, input logic [1:0] sz, input logic [31:0] d);
        @(negedge clk);
        bus.addr_i = a; bus.op_size_i = sz; bus.write_data_i = d; bus.write_en_i = 1'b1;
        @(negedge clk);
        bus.write_en_i = 1'b0;
    endtask

    // Scoreboard drain: compare head size and contents against the oldest
    // expected packet, then pop it.
    task automatic pop_and_check_head(input string tag);
        logic [31:0] d, expw, mask;
        int len, nb;
        logic [7:0] b [$];
        if (exp_len_q.size() == 0) begin
            $display("FAIL %s scoreboard empty: got nothing expected, required a queued packet", tag);
            miscompares++; vectors++;
            return;
        end
        len = exp_len_q.pop_front();
        for (int i = 0; i < len; i++) b.push_back(exp_byte_q.pop_front());
        mmio_rd(16'h1004, 2'd2, d);
        if (d !== 32'(len)) begin
            $display("FAIL %s head_size got %0d exp %0d", tag, d, len); miscompares++;
        end
        vectors++;
        for (int w = 0; w * 4 < len; w++) begin
            nb = (len - w * 4 < 4) ? len - w * 4 : 4;
            mask = (nb == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * nb)) - 1);
            expw = '0;
            for (int j = 0; j < nb; j++) expw[8*j +: 8] = b[w * 4 + j];
            mmio_rd(16'(w * 4), 2'd2, d);
            if ((d & mask) !== expw) begin
                $display("FAIL %s word%0d got %08h exp %08h", tag, w, d & mask, expw); miscompares++;
            end
            vectors++;
        end
        mmio_wr(16'h1010, 2'd2, 32'h1);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        if (bus.rx_ready_o !== 1'b0 || bus.read_data_o !== 32'h0 || bus.rx_interrupt_pending_o !== 1'b0) begin
            $display("FAIL reset_outputs got ready=%b rdata=%h irq=%b exp 0/0/0",
                     bus.rx_ready_o, bus.read_data_o, bus.rx_interrupt_pending_o);
            miscompares++;
        end
        vectors++;
        reset_i = 1'b0;
        @(negedge clk);
        if (bus.rx_ready_o !== 1'b1) begin
            $display("FAIL ready_after_reset got %b exp 1", bus.rx_ready_o); miscompares++;
        end
        vectors++;
        mmio_rd(16'h1040, 2'd2, d);
        if (d !== 32'h0) begin $display("FAIL reset_count got %0d exp 0", d); miscompares++; end
        vectors++;
        mmio_rd(16'h1044, 2'd2, d);
        if (d !== 32'h0) begin $display("FAIL reset_drop got %0d exp 0", d); miscompares++; end
        vectors++;
    endtask

    task automatic test_single();
        logic [31:0] d;
        gen_pkt(64, 1); expect_pkt(0, 64);
        send_range(0, 64, 1'b0, 1'b0);
        mmio_rd(16'h1010, 2'd2, d);
        if (d !== 32'h1) begin $display("FAIL single_pending got %0d exp 1", d); miscompares++; end
        vectors++;
        pop_and_check_head("single");
        mmio_rd(16'h1010, 2'd2, d);
        if (d !== 32'h0) begin $display("FAIL single_pending_after_pop got %0d exp 0", d); miscompares++; end
        vectors++;
        mmio_rd(16'h1040, 2'd2, d);
        if (d !== 32'h0) begin $display("FAIL single_count_after_pop got %0d exp 0", d); miscompares++; end
        vectors++;
    endtask

    task automatic test_partial();
        logic [31:0] d;
        gen_pkt(67, 2); expect_pkt(0, 67);
        send_range(0, 67, 1'b0, 1'b0);
        mmio_rd(16'h1004, 2'd2, d);
        if (d !== 32'h43) begin $display("FAIL partial_size got %0h exp 43", d); miscompares++; end
        vectors++;
        mmio_rd(16'h0042, 2'd0, d);
        if (d !== {24'h0, pkt_buf[66]}) begin
            $display("FAIL byte_read got %08h exp %08h", d, {24'h0, pkt_buf[66]}); miscompares++;
        end
        vectors++;
        mmio_rd(16'h0040, 2'd1, d);
        if (d !== {16'h0, pkt_buf[65], pkt_buf[64]}) begin
            $display("FAIL half_read got %08h exp %08h", d, {16'h0, pkt_buf[65], pkt_buf[64]}); miscompares++;
        end
        vectors++;
        mmio_rd(16'h0041, 2'd2, d);
        if (d !== 32'h0) begin $display("FAIL misaligned_read got %08h exp 0", d); miscompares++; end
        vectors++;
        pop_and_check_head("partial");
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        for (int p = 0; p < 5; p++) begin
            gen_pkt(100, 10 + p);
            if (p < 4) expect_pkt(0, 100);
            send_range(0, 100, 1'b0, 1'b0);
        end
        mmio_rd(16'h1040, 2'd2, d);
        if (d !== 32'h4) begin $display("FAIL full_count got %0d exp 4", d); miscompares++; end
        vectors++;
        mmio_rd(16'h1044, 2'd2, d);
        if (d !== 32'h1) begin $display("FAIL full_drop got %0d exp 1", d); miscompares++; end
        vectors++;
        for (int p = 0; p < 4; p++) pop_and_check_head($sformatf("ring%0d", p));
        gen_pkt(100, 20); expect_pkt(0, 100);
        send_range(0, 100, 1'b0, 1'b0);
        pop_and_check_head("wrap");
        mmio_wr(16'h1044, 2'd2, 32'h0);
    endtask

    task automatic test_drops();
        logic [31:0] d;
        gen_pkt(2052, 30);
        send_range(0, 2052, 1'b0, 1'b0);
        mmio_rd(16'h1044, 2'd2, d);
        if (d !== 32'h1) begin $display("FAIL oversize_drop got %0d exp 1", d); miscompares++; end
        vectors++;
        mmio_rd(16'h1040, 2'd2, d);
        if (d !== 32'h0) begin $display("FAIL oversize_count got %0d exp 0", d); miscompares++; end
        vectors++;
        gen_pkt(64, 31);
        send_range(0, 64, 1'b1, 1'b0);
        mmio_rd(16'h1044, 2'd2, d);
        if (d !== 32'h2) begin $display("FAIL error_drop got %0d exp 2", d); miscompares++; end
        vectors++;
        mmio_rd(16'h1040, 2'd2, d);
        if (d !== 32'h0) begin $display("FAIL error_count got %0d exp 0", d); miscompares++; end
        vectors++;
        mmio_wr(16'h1044, 2'd2, 32'h0);
        mmio_rd(16'h1044, 2'd2, d);
        if (d !== 32'h0) begin $display("FAIL drop_clear got %0d exp 0", d); miscompares++; end
        vectors++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        gen_pkt(40, 40); expect_pkt(0, 40); send_range(0, 40, 1'b0, 1'b0);
        gen_pkt(24, 41); expect_pkt(0, 24); send_range(0, 24, 1'b0, 1'b0);
        gen_pkt(33, 42); expect_pkt(0, 33);
        send_range(0, 33, 1'b0, 1'b1);
        // The pop issued with the commit removed the oldest packet.
        void'(exp_len_q.pop_front());
        for (int i = 0; i < 40; i++) void'(exp_byte_q.pop_front());
        mmio_rd(16'h1040, 2'd2, d);
        if (d !== 32'h2) begin $display("FAIL commit_pop_count got %0d exp 2", d); miscompares++; end
        vectors++;
        if (bus.rx_interrupt_pending_o !== 1'b0) begin
            $display("FAIL irq_disabled got %b exp 0", bus.rx_interrupt_pending_o); miscompares++;
        end
        vectors++;
        mmio_wr(16'h1014, 2'd2, 32'h1);
        if (bus.rx_interrupt_pending_o !== 1'b0) begin
            $display("FAIL irq_lag got %b exp 0", bus.rx_interrupt_pending_o); miscompares++;
        end
        vectors++;
        @(negedge clk);
        if (bus.rx_interrupt_pending_o !== 1'b1) begin
            $display("FAIL irq_assert got %b exp 1", bus.rx_interrupt_pending_o); miscompares++;
        end
        vectors++;
        pop_and_check_head("b2b0");
        pop_and_check_head("b2b1");
        if (bus.rx_interrupt_pending_o !== 1'b1) begin
            $display("FAIL irq_hold got %b exp 1", bus.rx_interrupt_pending_o); miscompares++;
        end
        vectors++;
        @(negedge clk);
        if (bus.rx_interrupt_pending_o !== 1'b0) begin
            $display("FAIL irq_deassert got %b exp 0", bus.rx_interrupt_pending_o); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_reset_midpacket();
        logic [31:0] d;
        gen_pkt(20, 50); send_range(0, 20, 1'b0, 1'b0);
        gen_pkt(16, 51); send_range(0, 16, 1'b1, 1'b0);
        @(negedge clk);
        if (bus.rx_interrupt_pending_o !== 1'b1) begin
            $display("FAIL pre_reset_irq got %b exp 1", bus.rx_interrupt_pending_o); miscompares++;
        end
        vectors++;
        gen_pkt(40, 52);
        for (int i = 0; i < 12; i += 4) begin
            @(negedge clk);
            bus.rx_valid_i = 1'b1; bus.rx_keep_i = 4'hF; bus.rx_last_i = 1'b0;
            bus.rx_data_i = {pkt_buf[i+3], pkt_buf[i+2], pkt_buf[i+1], pkt_buf[i]};
        end
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        exp_len_q.delete(); exp_byte_q.delete();
        if (bus.rx_interrupt_pending_o !== 1'b0) begin
            $display("FAIL reset_irq got %b exp 0", bus.rx_interrupt_pending_o); miscompares++;
        end
        vectors++;
        mmio_rd(16'h1040, 2'd2, d);
        if (d !== 32'h0) begin $display("FAIL reset_mid_count got %0d exp 0", d); miscompares++; end
        vectors++;
        mmio_rd(16'h1044, 2'd2, d);
        if (d !== 32'h0) begin $display("FAIL reset_mid_drop got %0d exp 0", d); miscompares++; end
        vectors++;
        expect_pkt(12, 40);
        send_range(12, 40, 1'b0, 1'b0);
        mmio_rd(16'h1040, 2'd2, d);
        if (d !== 32'h1) begin $display("FAIL resumed_count got %0d exp 1", d); miscompares++; end
        vectors++;
        pop_and_check_head("resumed");
        @(negedge clk);
        if (bus.rx_interrupt_pending_o !== 1'b0) begin
            $display("FAIL irq_after_reset got %b exp 0", bus.rx_interrupt_pending_o); miscompares++;
        end
        vectors++;
    endtask

    initial begin
        reset_i = 1'b1;
        bus.rx_valid_i = 1'b0; bus.rx_data_i = '0; bus.rx_keep_i = '0;
        bus.rx_last_i = 1'b0; bus.rx_error_i = 1'b0;
        bus.addr_i = '0; bus.write_en_i = 1'b0; bus.read_en_i = 1'b0;
        bus.op_size_i = 2'd2; bus.write_data_i = '0;
        test_reset();
        test_single();
        test_partial();
        test_overflow();
        test_drops();
        test_back_to_back();
        test_reset_midpacket();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
